// File: rtl/fft_frame_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_frame_buffer_if : requestor-side and fft-side line bus         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fft_frame_buffer_if;
  logic [511:0] data_in;
  logic         valid_in;
  logic         almost_full;
  logic [511:0] data_out;
  logic         next_out;
  logic [31:0]  frames_out;
  logic         overflow;

  modport master (
    output data_in, valid_in,
    input  almost_full, data_out, next_out, frames_out, overflow
  );

  modport slave (
    input  data_in, valid_in,
    output almost_full, data_out, next_out, frames_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_frame_buffer : gathers gapped read lines, replays gap-free     |
// | FFT frames (next pulse + FRAME_LINES beats). Rev 1.0               |
// +--------------------------------------------------------------------+
module fft_frame_buffer #(
  parameter int FRAME_LINES   = 4,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 8
) (
  input wire                clk,
  input wire                reset,
  fft_frame_buffer_if.slave io_bus
);
  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_BEAT_W = $clog2(FRAME_LINES) + 1;
  localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0]  c_FRAME_CNT = c_CNT_W'(FRAME_LINES);
  localparam logic [c_CNT_W-1:0]  c_SLACK_CNT = c_CNT_W'(ALMFULL_SLACK);
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(FRAME_LINES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [511:0]         r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_BEAT_W-1:0]  r_beat;
  logic [c_BEAT_W-1:0]  w_beat_nxt;
  logic [511:0]         r_data_out;
  logic [511:0]         w_data_nxt;
  logic                 r_next_out;
  logic                 w_next_nxt;
  logic [31:0]          r_frames_out;
  logic                 r_overflow;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_frame_done;
  logic [c_CNT_W-1:0]   w_free;

  // A push into a full buffer is still legal when a pop frees a slot that cycle.
  assign w_push = io_bus.valid_in && ((r_count != c_DEPTH_CNT) || w_pop);
  assign w_drop = io_bus.valid_in && !w_push;
  assign w_free = c_DEPTH_CNT - r_count;

  assign io_bus.almost_full = (w_free <= c_SLACK_CNT);
  assign io_bus.data_out    = r_data_out;
  assign io_bus.next_out    = r_next_out;
  assign io_bus.frames_out  = r_frames_out;
  assign io_bus.overflow    = r_overflow;

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_next_nxt   = 1'b0;
    w_data_nxt   = '0;
    w_beat_nxt   = r_beat;
    w_frame_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_count >= c_FRAME_CNT) begin
          w_state_nxt = S_LOAD;
          w_next_nxt  = 1'b1;
        end
      end
      S_LOAD: begin
        w_data_nxt  = r_mem[r_rd_ptr];
        w_pop       = 1'b1;
        w_beat_nxt  = c_BEAT_W'(1);
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (r_beat < c_LAST_BEAT) begin
          w_data_nxt = r_mem[r_rd_ptr];
          w_pop      = 1'b1;
          w_beat_nxt = r_beat + c_BEAT_W'(1);
        end else begin
          w_frame_done = 1'b1;
          w_beat_nxt   = '0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= io_bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_beat       <= '0;
      r_data_out   <= '0;
      r_next_out   <= 1'b0;
      r_frames_out <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_data_out <= w_data_nxt;
      r_next_out <= w_next_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
      if (w_frame_done) begin
        r_frames_out <= r_frames_out + 32'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fft_frame_buffer : directed self-checking bench                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fft_frame_buffer;
  localparam int FL    = 4;
  localparam int DEPTH = 16;
  localparam int SLACK = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fft_frame_buffer_if bus();

  fft_frame_buffer #(
    .FRAME_LINES  (FL),
    .DEPTH        (DEPTH),
    .ALMFULL_SLACK(SLACK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // Frame monitor: records next_out cycles and the FL beats following each pulse.
  int           mon_cyc    = 0;
  int           beats_left = 0;
  int           gap_err    = 0;
  int           idle_nz    = 0;
  int           next_cyc[$];
  logic [511:0] q_out[$];

  always @(negedge clk) begin
    mon_cyc++;
    if (reset) begin
      beats_left = 0;
    end else begin
      if (beats_left > 0) begin
        q_out.push_back(bus.data_out);
        beats_left--;
      end else if (bus.data_out !== '0) begin
        idle_nz++;
      end
      if (bus.next_out === 1'b1) begin
        if (beats_left != 0) gap_err++;
        next_cyc.push_back(mon_cyc);
        beats_left = FL;
      end
    end
  end

  function automatic logic [511:0] mk_line(input int i);
    return {16{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input int c);
    while (mon_cyc < c) step();
  endtask

  task automatic clear_mon();
    next_cyc.delete();
    q_out.delete();
    idle_nz = 0;
    gap_err = 0;
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    clear_mon();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in  = mk_line(99);
    repeat (3) step();
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    step();
    checks++; if (bus.next_out !== 1'b0) begin errors++; $display("FAIL reset_next: got %0h expected 0", bus.next_out); end
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.data_out); end
    checks++; if (bus.frames_out !== 32'd0) begin errors++; $display("FAIL reset_frames: got %0d expected 0", bus.frames_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0h expected 0", bus.overflow); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %0h expected 0", bus.almost_full); end
    clear_mon();
    repeat (8) step();
    checks++; if (next_cyc.size() != 0) begin errors++; $display("FAIL reset_valid_ignored: got %0d pulses expected 0", next_cyc.size()); end
  endtask

  task automatic test_single_frame();
    int c0;
    logic [511:0] v;
    apply_reset();
    c0 = mon_cyc;
    for (int k = 0; k < 4; k++) begin
      v = '0;
      v[7:0] = 8'(8'hA0 + k);
      bus.data_in  = v;
      bus.valid_in = 1'b1;
      step();
    end
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    go(c0 + 9);
    checks++; if (bus.frames_out !== 32'd0) begin errors++; $display("FAIL single_frames_early: got %0d expected 0", bus.frames_out); end
    step();
    checks++; if (bus.frames_out !== 32'd1) begin errors++; $display("FAIL single_frames: got %0d expected 1", bus.frames_out); end
    go(c0 + 14);
    checks++;
    if (next_cyc.size() != 1 || next_cyc[0] != c0 + 5) begin
      errors++; $display("FAIL single_next_timing: got %0d pulses first at %0d expected 1 at %0d", next_cyc.size(), (next_cyc.size() > 0) ? next_cyc[0] : -1, c0 + 5);
    end
    checks++;
    if (q_out.size() != 4) begin
      errors++; $display("FAIL single_beats: got %0d expected 4", q_out.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        v = '0;
        v[7:0] = 8'(8'hA0 + k);
        if (q_out[k] !== v) begin errors++; $display("FAIL single_data[%0d]: got %0h expected %0h", k, q_out[k], v); end
      end
    end
    checks++; if (idle_nz != 0) begin errors++; $display("FAIL single_idle_zero: got %0d nonzero idle beats expected 0", idle_nz); end
  endtask

  task automatic test_gapped();
    int c0;
    int at[4] = '{0, 3, 7, 20};
    apply_reset();
    c0 = mon_cyc;
    for (int k = 0; k < 4; k++) begin
      go(c0 + at[k]);
      if (k == 3) begin
        checks++; if (next_cyc.size() != 0) begin errors++; $display("FAIL gapped_early_next: got %0d pulses expected 0", next_cyc.size()); end
      end
      bus.data_in  = mk_line(100 + k);
      bus.valid_in = 1'b1;
      step();
      bus.valid_in = 1'b0;
    end
    go(c0 + 30);
    checks++;
    if (next_cyc.size() != 1 || next_cyc[0] != c0 + 22) begin
      errors++; $display("FAIL gapped_next_timing: got %0d pulses first at %0d expected 1 at %0d", next_cyc.size(), (next_cyc.size() > 0) ? next_cyc[0] : -1, c0 + 22);
    end
    checks++;
    if (q_out.size() != 4) begin
      errors++; $display("FAIL gapped_beats: got %0d expected 4", q_out.size());
    end else begin
      for (int k = 0; k < 4; k++)
        if (q_out[k] !== mk_line(100 + k)) begin errors++; $display("FAIL gapped_data[%0d]: got %0h expected %0h", k, q_out[k], mk_line(100 + k)); end
    end
    checks++; if (idle_nz != 0 || gap_err != 0) begin errors++; $display("FAIL gapped_contiguous: got idle_nz %0d gap_err %0d expected 0 0", idle_nz, gap_err); end
  endtask

  task automatic test_back_to_back();
    int c0;
    apply_reset();
    c0 = mon_cyc;
    for (int i = 0; i < 12; i++) begin
      bus.data_in  = mk_line(200 + i);
      bus.valid_in = 1'b1;
      step();
    end
    bus.valid_in = 1'b0;
    go(c0 + 21);
    checks++; if (bus.frames_out !== 32'd2) begin errors++; $display("FAIL b2b_frames_early: got %0d expected 2", bus.frames_out); end
    step();
    checks++; if (bus.frames_out !== 32'd3) begin errors++; $display("FAIL b2b_frames: got %0d expected 3", bus.frames_out); end
    go(c0 + 30);
    checks++;
    if (next_cyc.size() != 3 || next_cyc[0] != c0 + 5 || next_cyc[1] != c0 + 11 || next_cyc[2] != c0 + 17) begin
      errors++; $display("FAIL b2b_next_spacing: got %0d pulses expected 3 at offsets 5 11 17", next_cyc.size());
    end
    checks++;
    if (q_out.size() != 12) begin
      errors++; $display("FAIL b2b_beats: got %0d expected 12", q_out.size());
    end else begin
      for (int k = 0; k < 12; k++)
        if (q_out[k] !== mk_line(200 + k)) begin errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", k, q_out[k], mk_line(200 + k)); end
    end
  endtask

  // Pushing every cycle grows occupancy by 2 per frame period; full at offset 40.
  task automatic test_overflow();
    int c0;
    apply_reset();
    c0 = mon_cyc;
    for (int i = 0; i < 45; i++) begin
      if (i == 15) begin
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL ovf_af_at7: got %0h expected 0", bus.almost_full); end
      end
      if (i == 16) begin
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL ovf_af_at8: got %0h expected 1", bus.almost_full); end
      end
      if (i == 40) begin
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_drop: got %0h expected 0", bus.overflow); end
      end
      if (i == 41) begin
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drop: got %0h expected 1", bus.overflow); end
      end
      bus.data_in  = mk_line(300 + i);
      bus.valid_in = 1'b1;
      step();
    end
    bus.valid_in = 1'b0;
    go(c0 + 80);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0h expected 1", bus.overflow); end
    checks++; if (bus.frames_out !== 32'd11) begin errors++; $display("FAIL ovf_frames: got %0d expected 11", bus.frames_out); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL ovf_af_drained: got %0h expected 0", bus.almost_full); end
    checks++;
    if (q_out.size() != 44) begin
      errors++; $display("FAIL ovf_beats: got %0d expected 44", q_out.size());
    end else begin
      for (int j = 0; j < 44; j++)
        if (q_out[j] !== mk_line(300 + ((j < 40) ? j : j + 1))) begin
          errors++; $display("FAIL ovf_data[%0d]: got %0h expected %0h", j, q_out[j], mk_line(300 + ((j < 40) ? j : j + 1)));
        end
    end
  endtask

  task automatic test_full_pop();
    int c0;
    apply_reset();
    c0 = mon_cyc;
    for (int i = 0; i < 45; i++) begin
      if (i == 40 || i == 42) begin
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL fullpop_af[%0d]: got %0h expected 1", i, bus.almost_full); end
      end
      bus.data_in  = mk_line(400 + ((i < 40) ? i : i - 1));
      bus.valid_in = (i != 40);
      step();
    end
    bus.valid_in = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %0h expected 0", bus.overflow); end
    go(c0 + 80);
    checks++; if (bus.frames_out !== 32'd11) begin errors++; $display("FAIL fullpop_frames: got %0d expected 11", bus.frames_out); end
    checks++;
    if (q_out.size() != 44) begin
      errors++; $display("FAIL fullpop_beats: got %0d expected 44", q_out.size());
    end else begin
      for (int j = 0; j < 44; j++)
        if (q_out[j] !== mk_line(400 + j)) begin errors++; $display("FAIL fullpop_data[%0d]: got %0h expected %0h", j, q_out[j], mk_line(400 + j)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    int c1;
    apply_reset();
    c0 = mon_cyc;
    for (int k = 0; k < 4; k++) begin
      bus.data_in  = mk_line(500 + k);
      bus.valid_in = 1'b1;
      step();
    end
    bus.valid_in = 1'b0;
    go(c0 + 7);
    checks++; if (bus.data_out !== mk_line(501)) begin errors++; $display("FAIL midrst_beat2: got %0h expected %0h", bus.data_out, mk_line(501)); end
    reset = 1'b1;
    step();
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL midrst_data: got %0h expected 0", bus.data_out); end
    checks++; if (bus.next_out !== 1'b0) begin errors++; $display("FAIL midrst_next: got %0h expected 0", bus.next_out); end
    checks++; if (bus.frames_out !== 32'd0) begin errors++; $display("FAIL midrst_frames: got %0d expected 0", bus.frames_out); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL midrst_af: got %0h expected 0", bus.almost_full); end
    reset = 1'b0;
    repeat (3) step();
    clear_mon();
    c1 = mon_cyc;
    for (int k = 0; k < 4; k++) begin
      bus.data_in  = mk_line(600 + k);
      bus.valid_in = 1'b1;
      step();
    end
    bus.valid_in = 1'b0;
    go(c1 + 14);
    checks++;
    if (next_cyc.size() != 1 || next_cyc[0] != c1 + 5) begin
      errors++; $display("FAIL midrst_new_next: got %0d pulses expected 1 at %0d", next_cyc.size(), c1 + 5);
    end
    checks++;
    if (q_out.size() != 4) begin
      errors++; $display("FAIL midrst_new_beats: got %0d expected 4", q_out.size());
    end else begin
      for (int k = 0; k < 4; k++)
        if (q_out[k] !== mk_line(600 + k)) begin errors++; $display("FAIL midrst_new_data[%0d]: got %0h expected %0h", k, q_out[k], mk_line(600 + k)); end
    end
    checks++; if (bus.frames_out !== 32'd1) begin errors++; $display("FAIL midrst_new_frames: got %0d expected 1", bus.frames_out); end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    test_reset();
    test_single_frame();
    test_gapped();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
Sits between fft_requestor and fft in the AFU datapath. It collects 512-bit read-response lines that arrive in bursts with gaps and stores them in a circular buffer. Once a full FFT frame is buffered, it replays the frame to fft as one next pulse followed by FRAME_LINES back-to-back lines, because the streaming fft core cannot accept gaps inside a frame. almost_full lets the requestor throttle read issue so that in-flight responses never overflow the buffer.

Parameters:
FRAME_LINES, 4, 512-bit lines per FFT frame; power of 2, >=2
DEPTH, 16, buffer entries; power of 2, multiple of FRAME_LINES, >=2*FRAME_LINES
ALMFULL_SLACK, 8, almost_full asserts when free entries <= ALMFULL_SLACK; must be < DEPTH

Ports:
clk  in  1  clock (pClkDiv2 domain)
reset  in  1  synchronous, active-high reset
data_in  in  512  line from requestor
valid_in  in  1  data_in valid this cycle
almost_full  out  1  requestor must stop issuing reads
data_out  out  512  line to fft data_in
next_out  out  1  frame-start pulse to fft next_in
frames_out  out  32  count of frames emitted, wraps at 2^32
overflow  out  1  sticky; a write was dropped

Behaviour:
- Storage: mem[DEPTH]. Pointers wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Push: valid_in && count<DEPTH writes mem[wr_ptr] and increments wr_ptr. If valid_in && count==DEPTH and no pop occurs that cycle, the line is dropped and overflow is set to 1; it clears only on reset.
- Pop: one entry is popped per cycle in LOAD and STREAM states (see FSM).
- Simultaneous push and pop leave count unchanged. A push at count==DEPTH with a pop in the same cycle is accepted, not dropped.
- almost_full = (DEPTH - count) <= ALMFULL_SLACK. Combinational from registered count.
- Registered outputs: next_out, data_out, frames_out, overflow.
- data_out is 0 whenever the block is not presenting a frame line.
- FSM: IDLE, LOAD, STREAM.
  - IDLE: if count >= FRAME_LINES (registered count, excluding any same-cycle push), go to LOAD. Also register next_out<=1, data_out<=0.
  - LOAD (next_out high this cycle): register data_out<=mem[rd_ptr], pop, beat<=1, go to STREAM.
  - STREAM: data_out shows line beat-1.
    - If beat<FRAME_LINES: data_out<=mem[rd_ptr], pop, beat++.
    - Else: data_out<=0, frames_out++, go to IDLE.
- Resulting timing: next_out is high for exactly one cycle T. Frame line k appears on data_out at T+1+k, for k=0..FRAME_LINES-1, with no gaps.
- Minimum spacing between consecutive next_out pulses is FRAME_LINES+2 cycles.
- Latency: if the FRAME_LINES-th line of a frame is pushed at cycle t while the FSM is in IDLE, next_out is high at t+2.
- Line order is preserved exactly; there is no reordering.
- frames_out increments in the cycle after the last line of a frame is presented.
- Reset, whether idle or mid-frame: state<=IDLE, pointers/count/beat<=0, next_out<=0, data_out<=0, frames_out<=0, overflow<=0. A partial frame is discarded, and the fft must be reset together with this block.
- valid_in during reset is ignored.

Test Plan:
- Single frame: push lines 0xA0..0xA3 on consecutive cycles 10-13 -> next_out high at cycle 15, data_out=A0,A1,A2,A3 at 16-19, frames_out=1 at cycle 20, data_out=0 elsewhere.
- Gapped input: push 4 lines at cycles 0, 3, 7, 20 -> exactly one next_out pulse at cycle 22 with 4 contiguous data beats; no next_out before the 4th line.
- Back-to-back: push 12 lines continuously -> 3 next_out pulses spaced exactly 6 cycles apart, lines in order, frames_out=3.
- almost_full/overflow: DEPTH=16, SLACK=8, no draining (hold count by pushing while FSM is streaming), 8th resident line -> almost_full=1. Push 17 lines with no pops -> 17th dropped, overflow=1 and stays set; the 16 stored lines emerge unchanged.
- Full with simultaneous pop: count=16 during STREAM plus a push -> accepted, count stays 16, overflow remains 0.
- Reset mid-frame: assert reset at the 2nd data beat -> next cycle data_out=0, next_out=0, frames_out=0, almost_full=0. After release, 4 new lines produce a clean frame containing only the new data.
